// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button conditioning blocks on the 50 MHz board clock.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } dbnc_state_e;

  localparam int unsigned CLK_HZ = 32'd50000000;

  // Convert a millisecond interval to board-clock cycles for parameter overrides.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLK_HZ / 32'd1000);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with async active-high reset to a chosen idle value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounced level plus press/release pulses for one raw push-button.
// Optional auto-repeat of the press pulse is built when KEY_DEBOUNCER_REPEAT_EN is defined.
module key_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 32'd1000000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD = 32'd5000000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic BTN_RAW,
  output logic BTN_LEVEL,
  output logic BTN_PRESS,
  output logic BTN_RELEASE
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 32'd1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 32'd1);

  if (STABLE_CYCLES < 32'd2 || REPEAT_DELAY < 32'd1 || REPEAT_PERIOD < 32'd1) begin : g_param_check
    $error("key_debouncer: STABLE_CYCLES must be >= 2 and repeat intervals >= 1");
  end

  logic        sync_s;
  logic        pressed_s;
  logic        fsm_press_s;
  logic        fsm_release_s;
  logic        rep_fire_s;

  dbnc_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        press_q, release_q;

  // Idle the synchronizer at the released raw level so reset never looks like a press.
  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk_i (CLOCK_50),
    .rst_i (RESET),
    .d_i   (BTN_RAW),
    .q_o   (sync_s)
  );

  assign pressed_s = sync_s ^ ACTIVE_LOW;

  // Stability FSM: a new level must persist STABLE_CYCLES samples before acceptance.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    level_d       = level_q;
    fsm_press_s   = 1'b0;
    fsm_release_s = 1'b0;
    case (state_q)
      RELEASED: begin
        if (pressed_s) begin
          state_d = PRESS_CHK;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!pressed_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          level_d     = 1'b1;
          fsm_press_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (pressed_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d       = RELEASED;
          cnt_d         = '0;
          level_d       = 1'b0;
          fsm_release_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef KEY_DEBOUNCER_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = $clog2(REP_MAX + 32'd1);
  localparam logic [RW-1:0] REP_DELAY_C  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_PERIOD_C = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rep_q, rep_d;
  logic          rep_period_q, rep_period_d;

  // rep_q holds cycles since the last press pulse; it survives bounces and dies on release.
  always_comb begin
    rep_d        = rep_q;
    rep_period_d = rep_period_q;
    rep_fire_s   = 1'b0;
    if (fsm_press_s) begin
      rep_d        = RW'(1);
      rep_period_d = 1'b0;
    end else if ((state_q == HELD || state_q == RELEASE_CHK) && state_d != RELEASED) begin
      if (rep_q == (rep_period_q ? REP_PERIOD_C : REP_DELAY_C)) begin
        rep_fire_s   = 1'b1;
        rep_d        = RW'(1);
        rep_period_d = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end else begin
      rep_d        = '0;
      rep_period_d = 1'b0;
    end
  end

  // Repeat timer state.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      rep_q        <= '0;
      rep_period_q <= 1'b0;
    end else begin
      rep_q        <= rep_d;
      rep_period_q <= rep_period_d;
    end
  end
`else
  assign rep_fire_s = 1'b0;
`endif

  // FSM state and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= fsm_press_s | rep_fire_s;
      release_q <= fsm_release_s;
    end
  end

  assign BTN_LEVEL   = level_q;
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed table-driven bench for key_debouncer (STABLE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3).
module tb_key_debouncer;

`ifdef KEY_DEBOUNCER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  localparam int NV = 89;

  typedef struct packed {
    logic rst;
    logic raw;
    logic lvl;
    logic prs;
    logic rel;
  } vec_t;

  logic clk;
  logic rst;
  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  int checks;
  int errors;

  vec_t vecs [0:NV-1];

  key_debouncer #(
    .STABLE_CYCLES (4),
    .ACTIVE_LOW    (1'b1),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (3)
  ) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .BTN_RAW     (btn_raw),
    .BTN_LEVEL   (btn_level),
    .BTN_PRESS   (btn_press),
    .BTN_RELEASE (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic l, input logic p, input logic r);
    chk({tag, "_level"},   idx, btn_level,   l);
    chk({tag, "_press"},   idx, btn_press,   p);
    chk({tag, "_release"}, idx, btn_release, r);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic raw, input logic r);
    @(negedge clk);
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    btn_raw = 1'b0;

    // Raw applied before edge k reaches the FSM at edge k+2; acceptance lands at edge k+5.
    for (int i = 0; i < NV; i++) begin
      vecs[i].rst = (i < 3);
      if (i <= 9)       vecs[i].raw = 1'b0;
      else if (i <= 11) vecs[i].raw = 1'b1;
      else if (i == 12) vecs[i].raw = 1'b0;
      else if (i <= 20) vecs[i].raw = 1'b1;
      else if (i <= 50) vecs[i].raw = (((i - 21) / 2) % 2 == 0) ? 1'b0 : 1'b1;
      else if (i <= 58) vecs[i].raw = 1'b1;
      else if (i <= 78) vecs[i].raw = 1'b0;
      else              vecs[i].raw = 1'b1;
      vecs[i].lvl = ((i >= 8) && (i < 18)) || ((i >= 64) && (i < 84));
      vecs[i].prs = (i == 8) || (i == 64) ||
                    (REP && ((i == 16) || (i == 72) || (i == 75) || (i == 78) || (i == 81)));
      vecs[i].rel = (i == 18) || (i == 84);
    end

    #1;
    chk_all("reset_async", -1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].raw, vecs[i].rst);
      chk_all("vec", i, vecs[i].lvl, vecs[i].prs, vecs[i].rel);
    end

    // Fresh press to reach HELD.
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0);
      chk_all("mid_press", k, (k == 6), (k == 6), 1'b0);
    end
    // Release check runs to its third count without completing.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0);
      chk_all("mid_relchk", k, 1'b1, 1'b0, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_all("mid_rst_async", 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk_all("mid_rst_hold", 0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0);
      chk_all("mid_after", k, 1'b0, 1'b0, 1'b0);
    end
    // Full-latency acceptance shows the FSM restarted from RELEASED.
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0);
      chk_all("post_press", k, (k == 6), (k == 6), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
